// File: rtl/nw_counter_pkg.sv
// Shared encodings for the NW step counter slice.
// FSM states and run-mode values used by the counter top.
package nw_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

endpackage

// File: rtl/nw_prescaler.sv
// Prescaler for the NW step counter.
// Emits one tick every (pre_max+1) enabled, unheld clocks.
module nw_prescaler #(
  parameter int PRE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre_max,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic             at_max;

  assign at_max = (pre_cnt_q == pre_max);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick      = 1'b0;
    if (!en || clr) begin
      pre_cnt_d = '0;
    end else if (hold) begin
      pre_cnt_d = pre_cnt_q;
    end else if (at_max) begin
      pre_cnt_d = '0;
      tick      = 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/nw_step_counter.sv
// Prescaled modulo step counter for NW score-RAM sequencing.
// FSM, config latches, count and registered flags.
module nw_step_counter
  import nw_counter_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int PRE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  input  logic             oneshot,
  input  logic [PRE_W-1:0] pre_max,
  input  logic [CNT_W-1:0] cnt_max,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             term,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PRE_W-1:0] pre_lat_q, pre_lat_d;
  logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             term_q, term_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             run;
  logic             tick;

  assign run = en && (state_q == ST_RUN);

  nw_prescaler #(
    .PRE_W(PRE_W)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .hold   (hold),
    .clr    (clr),
    .pre_max(pre_lat_q),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pre_lat_d = pre_lat_q;
    cnt_lat_d = cnt_lat_q;
    count_d   = count_q;
    step_d    = 1'b0;
    term_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(oneshot);
          pre_lat_d = pre_max;
          cnt_lat_d = cnt_max;
          count_d   = '0;
        end
        ST_RUN: begin
          if (clr) begin
            mode_d    = mode_e'(oneshot);
            pre_lat_d = pre_max;
            cnt_lat_d = cnt_max;
            count_d   = '0;
          end else if (tick) begin
            step_d = 1'b1;
            if (count_q == cnt_lat_q) begin
              count_d = '0;
              term_d  = 1'b1;
              if (mode_q == MODE_ONESHOT)
                state_d = ST_DONE;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: count_d = '0;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_WRAP;
      pre_lat_q <= '0;
      cnt_lat_q <= '0;
      count_q   <= '0;
      step_q    <= 1'b0;
      term_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pre_lat_q <= pre_lat_d;
      cnt_lat_q <= cnt_lat_d;
      count_q   <= count_d;
      step_q    <= step_d;
      term_q    <= term_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign term  = term_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_nw_step_counter.sv
// Bench for nw_step_counter: time-based model plus directed pins.
// Model counts effective run clocks and derives count/flags arithmetically.
module tb_nw_step_counter;

  localparam int CNT_W = 4;
  localparam int PRE_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             hold = 1'b0;
  logic             clr = 1'b0;
  logic             oneshot = 1'b0;
  logic [PRE_W-1:0] pre_max = 2'd3;
  logic [CNT_W-1:0] cnt_max = 4'd2;
  logic [CNT_W-1:0] count;
  logic             step, term, done, busy;

  int errors = 0;
  int checks = 0;

  nw_step_counter #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .clr(clr),
    .oneshot(oneshot), .pre_max(pre_max), .cnt_max(cnt_max),
    .count(count), .step(step), .term(term), .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int t;
    int p;
    int c;
    int os;
    int count;
    int step;
    int term;
  } mdl_t;

  mdl_t m = '{default: 0};

  function automatic mdl_t nxt(mdl_t s, logic e, logic h, logic c,
                               logic o, int pm, int cm);
    mdl_t n = s;
    int per;
    n.step = 0;
    n.term = 0;
    if (!e) begin
      n.mode = 0; n.t = 0; n.count = 0;
    end else if (s.mode == 0 || (s.mode == 1 && c)) begin
      n.mode = 1; n.t = 0; n.count = 0;
      n.p = pm; n.c = cm; n.os = int'(o);
    end else if (s.mode == 1 && !h) begin
      n.t = s.t + 1;
      per = n.p + 1;
      n.step = (n.t % per == 0) ? 1 : 0;
      n.count = (n.t / per) % (n.c + 1);
      n.term = (n.t % (per * (n.c + 1)) == 0) ? 1 : 0;
      if (n.term == 1 && n.os == 1) n.mode = 2;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else m <= nxt(m, en, hold, clr, oneshot, int'(pre_max), int'(cnt_max));
  end

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("m_count", int'(count), m.count);
    chk("m_step", int'(step), m.step);
    chk("m_term", int'(term), m.term);
    chk("m_done", int'(done), (m.mode == 2) ? 1 : 0);
    chk("m_busy", int'(busy), (m.mode == 1) ? 1 : 0);
  end

  task automatic edges(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    edges(2);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step), 0);
    rst = 1'b0;
    edges(1);
    en = 1'b1;
    edges(1);
    chk("s1_busy", int'(busy), 1);
    for (int k = 1; k <= 24; k++) begin
      edges(1);
      if (k == 4) chk("s1_cnt4", int'(count), 1);
      if (k == 8) chk("s1_cnt8", int'(count), 2);
      if (k == 12) chk("s1_cnt12", int'(count), 0);
      chk("s1_step", int'(step), (k % 4 == 0) ? 1 : 0);
      chk("s1_term", int'(term), (k % 12 == 0) ? 1 : 0);
    end
    en = 1'b0; oneshot = 1'b1;
    edges(1);
    en = 1'b1;
    edges(1);
    edges(12);
    chk("s2_term", int'(term), 1);
    chk("s2_done", int'(done), 1);
    chk("s2_busy", int'(busy), 0);
    chk("s2_cnt", int'(count), 0);
    for (int k = 0; k < 3; k++) begin
      edges(1);
      chk("s2_nostep", int'(step), 0);
      chk("s2_hold_done", int'(done), 1);
    end
    en = 1'b0;
    edges(1);
    chk("s2_done_clr", int'(done), 0);
    oneshot = 1'b0; pre_max = 2'd0; cnt_max = 4'd0; en = 1'b1;
    edges(1);
    for (int k = 0; k < 4; k++) begin
      edges(1);
      chk("s3_step", int'(step), 1);
      chk("s3_term", int'(term), 1);
      chk("s3_cnt", int'(count), 0);
    end
    en = 1'b0; pre_max = 2'd3; cnt_max = 4'd2;
    edges(1);
    en = 1'b1;
    edges(7);
    chk("s4_cnt", int'(count), 1);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      chk("s4_frz_cnt", int'(count), 1);
      chk("s4_frz_step", int'(step), 0);
    end
    hold = 1'b0;
    edges(1);
    chk("s4_res1", int'(step), 0);
    edges(1);
    chk("s4_res2", int'(step), 1);
    chk("s4_res2_cnt", int'(count), 2);
    edges(3);
    en = 1'b0;
    edges(1);
    chk("s5_busy", int'(busy), 0);
    chk("s5_cnt", int'(count), 0);
    chk("s5_term", int'(term), 0);
    en = 1'b1;
    edges(3);
    pre_max = 2'd1; clr = 1'b1;
    edges(1);
    clr = 1'b0;
    chk("s5_clr_cnt", int'(count), 0);
    edges(1);
    chk("s5_a", int'(step), 0);
    edges(1);
    chk("s5_b", int'(step), 1);
    chk("s5_b_cnt", int'(count), 1);
    edges(1);
    chk("s5_c", int'(step), 0);
    edges(1);
    chk("s5_d", int'(step), 1);
    chk("s5_d_cnt", int'(count), 2);
    edges(1);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_cnt", int'(count), 0);
    chk("s6_rst_busy", int'(busy), 0);
    edges(1);
    rst = 1'b0; pre_max = 2'd0; cnt_max = 4'd2;
    edges(1);
    cnt_max = 4'd5;
    edges(2);
    chk("s6_cnt2", int'(count), 2);
    edges(1);
    chk("s6_wrap", int'(count), 0);
    chk("s6_term", int'(term), 1);
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    edges(3);
    chk("s6_relatch", int'(count), 3);
    for (int i = 0; i < 3000; i++) begin
      edges(1);
      en = ($urandom_range(0, 19) != 0);
      hold = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      oneshot = ($urandom_range(0, 3) == 0);
      pre_max = PRE_W'($urandom);
      cnt_max = CNT_W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    edges(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
